// File: rtl/rv_fetch_pkg.sv
// Purpose: shared types for the instruction prefetch path (fault codes, queue entry).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_fetch_pkg;

    localparam int FETCH_XLEN = 32;
    // Bytes per instruction word; the sequential fetch stride.
    localparam int INST_SIZE  = 4;

    typedef enum logic [1:0] {
        FETCH_OK     = 2'b00,
        FETCH_BUS    = 2'b01,
        FETCH_MALIGN = 2'b10
    } fetch_fault_t;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] inst;
        fetch_fault_t          fault;
    } fetch_entry_t;

    // True when the address is not on an instruction boundary.
    function automatic logic is_misaligned(input logic [FETCH_XLEN-1:0] addr);
        return (addr & FETCH_XLEN'(INST_SIZE - 1)) != '0;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: in-order queue of fetch_entry_t between bus responses and decode.
// Latency: push visible at the head one cycle later; no bypass.
// Backpressure: caller guarantees no push into a full queue (credit-limited); clear wins over pop.
//
// Ports: i_clr empties the queue, and a same-cycle i_push lands as the only entry;
//        o_vld/o_dat present the head, o_count is the occupancy, o_full is for checking.
module fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  fetch_entry_t             i_push_dat,
    input  logic                     i_pop,
    output logic                     o_vld,
    output fetch_entry_t             o_dat,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    fetch_entry_t r_mem [DEPTH];

    logic w_empty;
    logic w_do_pop;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign o_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop = i_pop && !w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clr) begin
            // Restart at slot 0 so a push during clear becomes the sole entry.
            r_rd_ptr <= '0;
            r_wr_ptr <= i_push ? (AW+1)'(1) : '0;
            if (i_push) begin
                r_mem[0] <= i_push_dat;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign o_vld   = !w_empty;
    assign o_dat   = r_mem[r_rd_ptr[AW-1:0]];
    assign o_count = r_wr_ptr - r_rd_ptr;

    // The issue credit rule must make this unreachable.
    a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && o_full && !i_clr));

endmodule

// File: rtl/rv_prefetch_unit.sv
// Purpose: sequential instruction prefetcher with a DEPTH-entry in-order queue and redirect flush.
// Latency: gnt in cycle G -> rvalid >= G+1 -> inst_valid >= one cycle after rvalid; req reasserts the cycle after flush.
// Backpressure: requests stop once queued + outstanding reaches DEPTH; inst_ready low holds the head.
//
// Ports: i_flush/i_flush_pc redirect; i_halt blocks new requests; o_req/o_req_addr/i_gnt request
//        channel; i_rvalid/i_rdata/i_rerr in-order responses; o_inst_* queue head with i_inst_ready
//        pop; o_count queue occupancy.
module rv_prefetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] RESET_VEC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    input  logic [XLEN-1:0]        i_flush_pc,
    input  logic                   i_halt,
    output logic                   o_req,
    output logic [XLEN-1:0]        o_req_addr,
    input  logic                   i_gnt,
    input  logic                   i_rvalid,
    input  logic [XLEN-1:0]        i_rdata,
    input  logic                   i_rerr,
    output logic                   o_inst_valid,
    output logic [XLEN-1:0]        o_inst,
    output logic [XLEN-1:0]        o_inst_pc,
    output logic [1:0]             o_inst_fault,
    input  logic                   i_inst_ready,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    // Stale responses can pile up across back-to-back flushes while new fetches
    // are already issuing, so the discard counter gets generous headroom.
    localparam int DW = CW + 8;

    logic [XLEN-1:0] r_fpc;          // next address to request
    logic [XLEN-1:0] r_rpc;          // pc of the next response that will be kept
    logic [CW-1:0]   r_outstanding;  // granted, not yet returned, current stream
    logic [DW-1:0]   r_discard;      // returns still owed from flushed streams
    logic            r_stop;
    logic            r_req;

    logic            w_gnt;
    logic            w_rsp_drop;
    logic            w_rsp_take;
    logic            w_misalign;
    logic            w_pop;
    logic            w_push;
    fetch_entry_t    w_push_dat;
    fetch_entry_t    w_head;
    logic [CW-1:0]   w_count;
    logic            w_full;

    logic [CW-1:0]   w_outstanding_nxt;
    logic [DW-1:0]   w_discard_nxt;
    logic [CW-1:0]   w_count_nxt;
    logic            w_stop_nxt;
    logic            w_credit_ok;

    assign o_req      = r_req && !i_halt;
    assign o_req_addr = {r_fpc[XLEN-1:2], 2'b00};

    assign w_gnt      = o_req && i_gnt;
    assign w_rsp_drop = i_rvalid && (r_discard != '0);
    assign w_rsp_take = i_rvalid && (r_discard == '0) && (r_outstanding != '0);
    assign w_misalign = i_flush && is_misaligned(i_flush_pc);
    assign w_pop      = o_inst_valid && i_inst_ready && !i_flush;

    // During a flush the only possible push is the misalignment marker; a
    // response in the flush cycle belongs to the old stream and is dropped.
    always_comb begin
        w_push     = w_rsp_take;
        w_push_dat = '{pc: r_rpc, inst: i_rdata, fault: (i_rerr ? FETCH_BUS : FETCH_OK)};
        if (i_flush) begin
            w_push     = w_misalign;
            w_push_dat = '{pc: i_flush_pc, inst: '0, fault: FETCH_MALIGN};
        end
    end

    fetch_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (i_flush),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_vld      (o_inst_valid),
        .o_dat      (w_head),
        .o_count    (w_count),
        .o_full     (w_full)
    );

    assign o_inst       = w_head.inst;
    assign o_inst_pc    = w_head.pc;
    assign o_inst_fault = w_head.fault;
    assign o_count      = w_count;

    always_comb begin
        w_outstanding_nxt = r_outstanding;
        w_discard_nxt     = r_discard;
        w_count_nxt       = w_count;
        w_stop_nxt        = r_stop;
        if (i_flush) begin
            // Everything still owed by the bus, including a grant taken this
            // cycle, is written off; a response this cycle settles one of them.
            w_discard_nxt     = r_discard + DW'(r_outstanding) + DW'(w_gnt)
                              - DW'(w_rsp_drop || w_rsp_take);
            w_outstanding_nxt = '0;
            w_count_nxt       = CW'(w_misalign);
            w_stop_nxt        = w_misalign;
        end else begin
            w_discard_nxt     = r_discard - DW'(w_rsp_drop);
            w_outstanding_nxt = r_outstanding + CW'(w_gnt) - CW'(w_rsp_take);
            w_count_nxt       = w_count + CW'(w_rsp_take) - CW'(w_pop);
            w_stop_nxt        = r_stop || (w_rsp_take && i_rerr);
        end
    end

    // Queue slots are reserved at grant time, so a returning response always fits.
    assign w_credit_ok = ({1'b0, w_count_nxt} + {1'b0, w_outstanding_nxt}) < (CW+1)'(DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fpc         <= RESET_VEC;
            r_rpc         <= RESET_VEC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_stop        <= 1'b0;
            r_req         <= 1'b0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_discard_nxt;
            r_stop        <= w_stop_nxt;
            r_req         <= !w_stop_nxt && w_credit_ok;
            if (i_flush) begin
                r_fpc <= i_flush_pc;
                r_rpc <= i_flush_pc;
            end else begin
                if (w_gnt) begin
                    r_fpc <= r_fpc + XLEN'(INST_SIZE);
                end
                if (w_rsp_take) begin
                    r_rpc <= r_rpc + XLEN'(INST_SIZE);
                end
            end
        end
    end

    // A response with nothing in flight means the bus and this unit disagree.
    a_rsp_has_owner : assert property (@(posedge clk) disable iff (!rst_n)
        !(i_rvalid && (r_discard == '0) && (r_outstanding == '0)));

endmodule
